// File: rtl/phy_mdio_master.sv
// Clause 22 MDIO frame engine: serialises one register read/write per command, timed by an external MDC level.
// Optional macro MDIO_PREAMBLE_SUPPRESS_EN adds cmd_nopre, which skips the preamble for that command.
module phy_mdio_master #(
    parameter int PRE_LEN = 32
) (
    input  logic        rgmii_clk_in,
    input  logic        sys_rst_n,
    input  logic        mdc_in,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_rd,
    input  logic [4:0]  cmd_phyad,
    input  logic [4:0]  cmd_regad,
    input  logic [15:0] cmd_wdata,
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    input  logic        cmd_nopre,
`endif
    input  logic        mdio_i,
    output logic        mdio_o,
    output logic        mdio_t,
    output logic        rd_valid,
    output logic [15:0] rd_data,
    output logic        done,
    output logic        busy
);
    typedef enum logic [2:0] {S_IDLE, S_START, S_PRE, S_HDR, S_TA, S_DATA, S_END} state_t;

    state_t      state, state_nxt;
    logic        mdc_d, fall, rise, accept, in_frame;
    logic [1:0]  mdio_sync;
    logic [5:0]  cnt, cnt_nxt;
    logic [31:0] sh;
    logic [15:0] rd_sh;
    logic        is_rd, nopre, nopre_in;
    logic        last, shift, drv_o, drv_t;

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    assign nopre_in = cmd_nopre;
`else
    assign nopre_in = 1'b0;
`endif

    assign fall     = mdc_d & ~mdc_in;
    assign rise     = ~mdc_d & mdc_in;
    assign accept   = cmd_valid & cmd_ready;
    assign in_frame = state inside {S_START, S_PRE, S_HDR, S_TA, S_DATA};

    // cnt holds the number of bits already driven in the current field
    always_comb begin
        last = 1'b0;
        case (state)
            S_PRE:   last = (cnt == 6'(PRE_LEN));
            S_HDR:   last = (cnt == 6'd14);
            S_TA:    last = (cnt == 6'd2);
            S_DATA:  last = (cnt == 6'd16);
            default: last = 1'b0;
        endcase
    end

    always_ff @(posedge rgmii_clk_in or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= S_IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept)        state_nxt = S_START;
            S_START: if (fall)          state_nxt = nopre ? S_HDR : S_PRE;
            S_PRE:   if (fall && last)  state_nxt = S_HDR;
            S_HDR:   if (fall && last)  state_nxt = S_TA;
            S_TA:    if (fall && last)  state_nxt = S_DATA;
            S_DATA:  if (fall && last)  state_nxt = S_END;
            S_END:                      state_nxt = S_IDLE;
            default:                    state_nxt = S_IDLE;
        endcase
    end

    // Value to present on the next fall; sh[31] is always the next post-preamble bit
    always_comb begin
        cmd_ready = (state == S_IDLE);
        busy      = (state != S_IDLE);
        drv_o     = 1'b1;
        drv_t     = 1'b0;
        shift     = 1'b0;
        cnt_nxt   = cnt + 6'd1;
        case (state)
            S_START: begin
                cnt_nxt = 6'd1;
                if (nopre) begin
                    drv_o = sh[31];
                    shift = 1'b1;
                end
            end
            S_PRE: if (last) begin
                drv_o   = sh[31];
                shift   = 1'b1;
                cnt_nxt = 6'd1;
            end
            S_HDR: begin
                drv_o = sh[31];
                shift = 1'b1;
                if (last) begin
                    drv_t   = is_rd;
                    cnt_nxt = 6'd1;
                end
            end
            S_TA: begin
                drv_o = sh[31];
                drv_t = is_rd;
                shift = 1'b1;
                if (last) cnt_nxt = 6'd1;
            end
            S_DATA: begin
                drv_o = sh[31];
                drv_t = is_rd | last;
                shift = ~last;
            end
            default: ;
        endcase
        if (drv_t) drv_o = 1'b1;
    end

    always_ff @(posedge rgmii_clk_in or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            mdc_d     <= 1'b0;
            mdio_sync <= 2'b11;
            cnt       <= '0;
            sh        <= '0;
            rd_sh     <= '0;
            is_rd     <= 1'b0;
            nopre     <= 1'b0;
            mdio_o    <= 1'b1;
            mdio_t    <= 1'b1;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            done      <= 1'b0;
        end else begin
            mdc_d     <= mdc_in;
            mdio_sync <= {mdio_sync[0], mdio_i};
            rd_valid  <= 1'b0;
            done      <= 1'b0;
            if (accept) begin
                is_rd <= cmd_rd;
                nopre <= nopre_in;
                cnt   <= '0;
                rd_sh <= '0;
                sh    <= {2'b01, (cmd_rd ? 2'b10 : 2'b01), cmd_phyad, cmd_regad, 2'b10, cmd_wdata};
            end
            if (fall && in_frame) begin
                mdio_o <= drv_o;
                mdio_t <= drv_t;
                cnt    <= cnt_nxt;
                if (shift) sh <= {sh[30:0], 1'b0};
                if (state == S_DATA && last) begin
                    done <= 1'b1;
                    if (is_rd) begin
                        rd_valid <= 1'b1;
                        rd_data  <= rd_sh;
                    end
                end
            end
            if (rise && state == S_DATA && is_rd) rd_sh <= {rd_sh[14:0], mdio_sync[1]};
        end
    end
endmodule

// File: tb/tb_phy_mdio_master.sv
// Scoreboard bench for phy_mdio_master: stimulus pushes expected frames, a monitor checks each done pulse.
module tb_phy_mdio_master;
    localparam int PL = 32;

    logic        rgmii_clk_in = 1'b0;
    logic        sys_rst_n    = 1'b0;
    logic        mdc_in       = 1'b0;
    logic        cmd_valid    = 1'b0;
    logic        cmd_rd       = 1'b0;
    logic [4:0]  cmd_phyad    = '0;
    logic [4:0]  cmd_regad    = '0;
    logic [15:0] cmd_wdata    = '0;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    logic        cmd_nopre    = 1'b0;
`endif
    logic        mdio_i       = 1'b1;
    logic        cmd_ready, mdio_o, mdio_t, rd_valid, done, busy;
    logic [15:0] rd_data;

    phy_mdio_master #(.PRE_LEN(PL)) dut (
        .rgmii_clk_in(rgmii_clk_in), .sys_rst_n(sys_rst_n), .mdc_in(mdc_in),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rd(cmd_rd),
        .cmd_phyad(cmd_phyad), .cmd_regad(cmd_regad), .cmd_wdata(cmd_wdata),
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
        .cmd_nopre(cmd_nopre),
`endif
        .mdio_i(mdio_i), .mdio_o(mdio_o), .mdio_t(mdio_t),
        .rd_valid(rd_valid), .rd_data(rd_data), .done(done), .busy(busy)
    );

    always #5 rgmii_clk_in = ~rgmii_clk_in;

    // MDC generator model: divide-by-11
    int div = 0;
    int cyc = 0;
    always @(posedge rgmii_clk_in) begin
        div    <= (div == 10) ? 0 : div + 1;
        mdc_in <= (div < 5);
        cyc    <= cyc + 1;
    end

    int n_chk = 0, n_fail = 0;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rd;
        logic [63:0] bits;
        int          nbits;
        int          len;
        logic [15:0] rdat;
    } exp_t;
    exp_t sb[$];

    // PHY model: bit index counted from the master's first driven bit; answers only when the bus is released
    int          bidx = 1000, phy_base = PL;
    logic [15:0] phy_data = '0;
    logic        p_t_q = 1'b1, p_mdc_q = 1'b0;
    logic [3:0]  di;
    always @(negedge rgmii_clk_in) begin
        if (p_t_q && !mdio_t)      bidx = 0;
        else if (p_mdc_q && !mdc_in) bidx++;
        p_t_q   = mdio_t;
        p_mdc_q = mdc_in;
        mdio_i  = 1'b1;
        if (mdio_t && bidx == phy_base + 15) mdio_i = 1'b0;
        else if (mdio_t && bidx >= phy_base + 16 && bidx <= phy_base + 31) begin
            di     = 4'(15 - (bidx - phy_base - 16));
            mdio_i = phy_data[di];
        end
    end

    // Monitor: captures driven bits on MDC rises and checks every done pulse against the scoreboard
    logic [63:0] cap_bits = '0;
    int          cap_n = 0, rises = 0, done_cyc = 0;
    logic        m_t_q = 1'b1, m_mdc_q = 1'b0, done_q = 1'b0;
    exp_t        e;
    always @(negedge rgmii_clk_in) begin
        if (m_t_q && !mdio_t) begin
            cap_bits = '0;
            cap_n    = 0;
            rises    = 0;
        end
        if (!m_mdc_q && mdc_in) begin
            rises++;
            if (!mdio_t) begin
                cap_bits = {cap_bits[62:0], mdio_o};
                cap_n++;
            end
        end
        if (done_q) chk("done_width", 64'(done), 64'd0);
        if (done) begin
            done_cyc = cyc;
            chk("done_expected", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("rd_valid_at_done", 64'(rd_valid), 64'(e.rd));
                chk("rd_data_at_done", 64'(rd_data), 64'(e.rdat));
                chk("driven_bit_count", 64'(cap_n), 64'(e.nbits));
                chk("driven_bits", cap_bits, e.bits);
                chk("frame_mdc_cycles", 64'(rises), 64'(e.len));
                chk("mdio_t_released", 64'(mdio_t), 64'd1);
            end
        end else if (rd_valid) begin
            n_chk++;
            n_fail++;
            $display("FAIL rd_valid_without_done: got 1, expected 0");
        end
        m_t_q   = mdio_t;
        m_mdc_q = mdc_in;
        done_q  = done;
    end

    function automatic logic [63:0] frame_bits(input logic rd, input logic [4:0] pa, input logic [4:0] ra,
                                               input logic [15:0] wd, input logic nop);
        logic [13:0] hdr;
        logic [63:0] b;
        b   = '0;
        hdr = {2'b01, (rd ? 2'b10 : 2'b01), pa, ra};
        if (!nop) for (int i = 0; i < PL; i++) b = {b[62:0], 1'b1};
        for (int i = 13; i >= 0; i--) b = {b[62:0], hdr[i]};
        if (!rd) begin
            b = {b[62:0], 2'b10};
            for (int i = 15; i >= 0; i--) b = {b[62:0], wd[i]};
        end
        return b;
    endfunction

    int acc_cyc = 0;
    task automatic issue(input logic rd, input logic [4:0] pa, input logic [4:0] ra, input logic [15:0] wd,
                         input logic nop, input logic [63:0] bits, input logic [15:0] erd, input logic keep);
        exp_t x;
        int   n;
        x.rd    = rd;
        x.bits  = bits;
        x.nbits = (nop ? 0 : PL) + 14 + (rd ? 0 : 18);
        x.len   = (nop ? 0 : PL) + 32;
        x.rdat  = erd;
        sb.push_back(x);
        cmd_valid = 1'b1;
        cmd_rd    = rd;
        cmd_phyad = pa;
        cmd_regad = ra;
        cmd_wdata = wd;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
        cmd_nopre = nop;
`endif
        n = 0;
        while (!cmd_ready && n < 3000) begin
            @(negedge rgmii_clk_in);
            n++;
        end
        if (!cmd_ready) begin
            n_chk++;
            n_fail++;
            $display("FAIL accept_timeout: cmd_ready stayed 0, expected 1");
        end
        acc_cyc = cyc;
        @(negedge rgmii_clk_in);
        if (!keep) cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb.size() != 0 || busy) && n < 3000) begin
            @(negedge rgmii_clk_in);
            n++;
        end
        if (n >= 3000) begin
            n_chk++;
            n_fail++;
            $display("FAIL frame_timeout: %0d frames pending, expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        int n;
        repeat (3) @(negedge rgmii_clk_in);
        chk("rst_mdio_o", 64'(mdio_o), 64'd1);
        chk("rst_mdio_t", 64'(mdio_t), 64'd1);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_rd_valid", 64'(rd_valid), 64'd0);
        chk("rst_rd_data", 64'(rd_data), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        sys_rst_n = 1'b1;
        repeat (2) @(negedge rgmii_clk_in);

        // write 0x1140 to PHY 1 reg 0
        phy_base = PL;
        issue(1'b0, 5'h01, 5'h00, 16'h1140, 1'b0, 64'hFFFF_FFFF_5082_1140, 16'h0000, 1'b0);
        chk("busy_in_frame", 64'(busy), 64'd1);
        chk("ready_in_frame", 64'(cmd_ready), 64'd0);
        wait_idle();

        // read PHY 7 reg 2, PHY returns 0xABCD
        phy_data = 16'hABCD;
        issue(1'b1, 5'h07, 5'h02, 16'h0000, 1'b0, 64'h0000_3FFF_FFFF_D8E2, 16'hABCD, 1'b0);
        wait_idle();

        // back-to-back write then read with cmd_valid held
        issue(1'b0, 5'h03, 5'h04, 16'hA5A5, 1'b0, frame_bits(1'b0, 5'h03, 5'h04, 16'hA5A5, 1'b0), 16'hABCD, 1'b1);
        phy_data = 16'h1234;
        issue(1'b1, 5'h05, 5'h1F, 16'h0000, 1'b0, frame_bits(1'b1, 5'h05, 5'h1F, 16'h0000, 1'b0), 16'h1234, 1'b0);
        chk("b2b_accept_cycle", 64'(acc_cyc), 64'(done_cyc + 1));
        wait_idle();

        // command pulsed while busy must not disturb the in-flight write
        issue(1'b0, 5'h0A, 5'h0B, 16'h0F0F, 1'b0, frame_bits(1'b0, 5'h0A, 5'h0B, 16'h0F0F, 1'b0), 16'h1234, 1'b0);
        repeat (200) @(negedge rgmii_clk_in);
        cmd_valid = 1'b1; cmd_rd = 1'b1; cmd_phyad = 5'h15; cmd_regad = 5'h03; cmd_wdata = 16'hFFFF;
        repeat (3) @(negedge rgmii_clk_in);
        cmd_valid = 1'b0;
        wait_idle();
        repeat (50) @(negedge rgmii_clk_in);
        chk("stray_cmd_ignored", 64'(busy), 64'd0);
        chk("rd_data_kept_by_write", 64'(rd_data), 64'h1234);

        // reset during data bit 5 of a read
        phy_data = 16'h9999;
        issue(1'b1, 5'h01, 5'h01, 16'h0000, 1'b0, frame_bits(1'b1, 5'h01, 5'h01, 16'h0000, 1'b0), 16'h9999, 1'b0);
        n = 0;
        while (bidx != PL + 21 && n < 3000) begin
            @(negedge rgmii_clk_in);
            n++;
        end
        chk("reached_data_bit5", 64'(bidx), 64'(PL + 21));
        sys_rst_n = 1'b0;
        #1;
        chk("abort_mdio_t", 64'(mdio_t), 64'd1);
        chk("abort_busy", 64'(busy), 64'd0);
        sb.delete();
        repeat (3) @(negedge rgmii_clk_in);
        sys_rst_n = 1'b1;
        @(negedge rgmii_clk_in);
        chk("post_abort_ready", 64'(cmd_ready), 64'd1);
        chk("post_abort_busy", 64'(busy), 64'd0);
        chk("post_abort_rd_data", 64'(rd_data), 64'd0);
        repeat (800) @(negedge rgmii_clk_in);
        chk("post_abort_mdio_t", 64'(mdio_t), 64'd1);

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
        // preamble suppressed read of PHY 31 reg 31
        phy_base = 0;
        phy_data = 16'h5A3C;
        issue(1'b1, 5'h1F, 5'h1F, 16'h0000, 1'b1, 64'h0000_0000_0000_1BFF, 16'h5A3C, 1'b0);
        wait_idle();
        cmd_nopre = 1'b0;
        phy_base  = PL;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/phy_mdio_master.md
Name: phy_mdio_master

Overview:
- IEEE 802.3 Clause 22 management frame engine.
- Serialises single-register read/write commands onto MDIO, timed by the MDC produced by the neighbouring MDC generator (divide-by-11 of rgmii_clk_in).
- Consumes that MDC as a same-domain level and derives edge strobes from it. Drives the MDIO pad through a tri-state triple. Returns read data to the management/config logic.

Parameters:
- PRE_LEN, 32, preamble length in MDC cycles (all ones); legal 1..32.

Ports:
- rgmii_clk_in  in  1  system clock; also the source clock of MDC
- sys_rst_n  in  1  asynchronous active-low reset
- mdc_in  in  1  MDC level from the MDC generator; synchronous to rgmii_clk_in
- cmd_valid  in  1  command request
- cmd_ready  out  1  engine idle, command accepted when valid&ready
- cmd_rd  in  1  1=read (OP 10), 0=write (OP 01)
- cmd_phyad  in  5  PHY address
- cmd_regad  in  5  register address
- cmd_wdata  in  16  write data
- mdio_i  in  1  MDIO pad input (asynchronous)
- mdio_o  out  1  MDIO output value
- mdio_t  out  1  tri-state enable, 1 = released/hi-Z
- rd_valid  out  1  one-cycle pulse, rd_data valid
- rd_data  out  16  last read data
- done  out  1  one-cycle pulse at frame end (read or write)
- busy  out  1  frame in progress

Behaviour:
- Reset values: mdio_o=1, mdio_t=1, cmd_ready=1, rd_valid=0, rd_data=0, done=0, busy=0. State=IDLE, counters=0, shift reg=0.
- Edge strobes: mdc_d registered copy of mdc_in. fall = mdc_d & ~mdc_in; rise = ~mdc_d & mdc_in. Each strobe lasts 1 clock.
- mdio_i passes through a 2-flop synchroniser, reset to 1, before use.
- Accept: in IDLE, cmd_valid&cmd_ready latches all cmd_* fields. cmd_ready drops and busy rises the next cycle. cmd_* are ignored while busy.
- MDIO output changes only on fall strobes. Read data is sampled only on rise strobes, using the synchronised value.
- States:
  - IDLE: waits for accept, then START_WAIT.
  - START_WAIT: first fall → PRE; drive mdio_t=0, mdio_o=1.
  - PRE: PRE_LEN bits of 1. Count falls; at the PRE_LEN-th fall → HDR.
  - HDR: 14 bits MSB first: ST=01, OP, PHYAD, REGAD. After the 14th bit → TA.
  - TA:
    - Write: drive 1 then 0.
    - Read: mdio_t=1 on both TA bits; the PHY's 0 is not checked.
  - DATA: 16 bits MSB first.
    - Write: drive cmd_wdata.
    - Read: mdio_t stays 1; shift in on each rise, 16 samples.
  - END: next fall after the last data bit: mdio_t=1, mdio_o=1. Pulse done. For a read, also pulse rd_valid and update rd_data in the same cycle. Next cycle cmd_ready=1, busy=0 → IDLE.
- Frame length: PRE_LEN+32 MDC cycles. Default 64 MDC = 704 clocks ±11 of start alignment.
- rd_data holds its value until the next read completes. It is unchanged by writes.
- Back-to-back: a command presented with cmd_valid held high is accepted in the first IDLE cycle. Its preamble starts at the next fall; no extra idle MDC cycles are inserted.
- mdc_in stuck (no edges): engine waits indefinitely; no timeout.
- sys_rst_n asserted mid-frame: immediate return to reset values. mdio_t=1 releases the bus asynchronously. No done or rd_valid for the aborted frame.

Optional Feature:
- Macro MDIO_PREAMBLE_SUPPRESS_EN.
- Defined: adds input cmd_nopre (1 bit), latched with the command. When 1, PRE is skipped: START_WAIT → HDR, and the first fall drives ST bit 0. Frame = 32 MDC cycles.
- Undefined: port absent; preamble is always PRE_LEN bits.

Test Plan:
- Write PHYAD=0x01, REGAD=0x00, data=0x1140. Capture mdio_o on rise strobes → 32×1, 01, 01, 00001, 00000, 10, 0001000101000000. mdio_t=0 throughout; single done pulse; no rd_valid.
- Read PHYAD=0x07, REGAD=0x02, PHY model drives TA 0 then 0xABCD. Required: mdio_t=1 from the first TA bit; rd_valid single pulse with rd_data=0xABCD; done in the same cycle.
- Two commands with cmd_valid held: write then read. Second accepted the cycle cmd_ready returns. Two complete frames, each 64 MDC. No command dropped.
- Pulse cmd_valid while busy with different fields → ignored; the in-flight frame bits are unchanged.
- Assert sys_rst_n=0 at data bit 5 of a read → mdio_t=1, busy=0, cmd_ready=1 after release. No rd_valid; rd_data=0.
- With MDIO_PREAMBLE_SUPPRESS_EN, cmd_nopre=1, read 0x1F/0x1F → first driven bit is 0 (ST). Frame is 32 MDC; rd_data matches the model.
